// File: rtl/pattern_checker.sv
// Recomputes the generator's expected pixel per position and counts per-frame mismatches.
// Latency: err_cnt updates 1 cycle after a bad pixel, frame_done 2 cycles after the last pixel; no backpressure.
module pattern_checker #(
    parameter int DW       = 12,
    parameter int LINE_LEN = 1290,
    parameter int REG_LEN  = 4096,
    parameter int LINES    = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          f_sync,
    input  logic          sync,
    input  logic [2:0]    mode,
    input  logic [DW-1:0] const_val,
    input  logic [1:0]    x_sel,
    input  logic [1:0]    y_sel,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    output logic          busy,
    output logic [15:0]   err_cnt,
    output logic          line_err,
    output logic          frame_done,
    output logic          frame_pass,
    output logic [4:0]    first_err_line,
    output logic [11:0]   first_err_pix
);

    localparam int MAX_LEN = (REG_LEN > LINE_LEN) ? REG_LEN : LINE_LEN;
    localparam int PW      = $clog2(MAX_LEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LINE = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] M_REG   = 3'b001;
    localparam logic [2:0] M_CONST = 3'b010;
    localparam logic [2:0] M_W1    = 3'b011;
    localparam logic [2:0] M_B1    = 3'b100;
    localparam logic [2:0] M_W2    = 3'b101;
    localparam logic [2:0] M_B2    = 3'b110;
    localparam logic [2:0] M_RAMP  = 3'b111;

    logic [1:0]    state;
    logic [2:0]    mode_r;
    logic [DW-1:0] const_r;
    logic [DW-1:0] dx_r;
    logic [DW-1:0] dy_r;
    logic [4:0]    line_idx;
    logic [PW-1:0] pix_idx;
    logic [DW-1:0] y_acc;
    logic [DW-1:0] x_acc;
    logic          line_has_err;

    // Registered error event: compare result plus its location, applied next cycle
    logic          err_evt;
    logic [4:0]    err_evt_line;
    logic [11:0]   err_evt_pix;

    logic [DW-1:0] dx_in;
    logic [DW-1:0] dy_in;
    logic [DW-1:0] expected;
    logic [DW-1:0] pix_dw;
    logic [PW-1:0] line_len;
    logic          pix_acc;
    logic          mismatch;
    logic          last_pix;
    logic          short_line;
    logic          overrun;
    logic          last_line;
    logic          line_close;
    logic          frame_start;

    always_comb begin
        dx_in = '0;
        case (x_sel)
            2'b01:   dx_in = DW'(1);
            2'b10:   dx_in = DW'(4);
            2'b11:   dx_in = DW'(8);
            default: dx_in = '0;
        endcase
        dy_in = '0;
        case (y_sel)
            2'b01:   dy_in = DW'(1);
            2'b10:   dy_in = DW'(16);
            2'b11:   dy_in = DW'(1290);
            default: dy_in = '0;
        endcase
    end

    assign pix_dw = DW'(pix_idx);

    // 2x2 checker: adding 2*((L>>1)&1) only flips bit 1, so bit1 = P[1]^L[1]
    always_comb begin
        expected = '0;
        case (mode_r)
            M_REG:   expected = pix_dw ^ (pix_dw >> 1);
            M_CONST: expected = const_r;
            M_W1:    expected = {DW{pix_idx[0] ^ line_idx[0]}};
            M_B1:    expected = {DW{~(pix_idx[0] ^ line_idx[0])}};
            M_W2:    expected = {DW{pix_idx[1] ^ line_idx[1]}};
            M_B2:    expected = {DW{~(pix_idx[1] ^ line_idx[1])}};
            M_RAMP:  expected = x_acc;
            default: expected = '0;
        endcase
    end

    assign line_len    = (mode_r == M_REG) ? PW'(REG_LEN) : PW'(LINE_LEN);
    assign pix_acc     = (state == S_LINE) && pix_valid && !sync;
    assign mismatch    = pix_acc && (pix_data != expected);
    assign last_pix    = pix_acc && (pix_idx == line_len - PW'(1));
    assign short_line  = (state == S_LINE) && sync;
    assign overrun     = (state == S_GAP) && pix_valid && !sync;
    assign last_line   = (line_idx == 5'(LINES - 1));
    assign line_close  = last_pix || short_line;
    assign frame_start = (state == S_IDLE) && f_sync && sync && (mode != 3'b000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            mode_r         <= '0;
            const_r        <= '0;
            dx_r           <= '0;
            dy_r           <= '0;
            line_idx       <= '0;
            pix_idx        <= '0;
            y_acc          <= '0;
            x_acc          <= '0;
            line_has_err   <= 1'b0;
            err_evt        <= 1'b0;
            err_evt_line   <= '0;
            err_evt_pix    <= '0;
            busy           <= 1'b0;
            err_cnt        <= '0;
            line_err       <= 1'b0;
            frame_done     <= 1'b0;
            frame_pass     <= 1'b0;
            first_err_line <= 5'h1F;
            first_err_pix  <= 12'hFFF;
        end else begin
            line_err     <= 1'b0;
            frame_done   <= 1'b0;
            err_evt      <= mismatch | short_line | overrun;
            // Overrun pixels belong to the line that just closed
            err_evt_line <= overrun ? line_idx - 5'd1 : line_idx;
            err_evt_pix  <= short_line ? 12'hFFF : (overrun ? 12'(LINE_LEN) : 12'(pix_idx));

            if (err_evt && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
                if (err_cnt == 16'd0) begin
                    first_err_line <= err_evt_line;
                    first_err_pix  <= err_evt_pix;
                end
            end

            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        state          <= S_LINE;
                        mode_r         <= mode;
                        const_r        <= const_val;
                        dx_r           <= dx_in;
                        dy_r           <= dy_in;
                        line_idx       <= '0;
                        pix_idx        <= '0;
                        y_acc          <= '0;
                        x_acc          <= '0;
                        line_has_err   <= 1'b0;
                        busy           <= 1'b1;
                        err_cnt        <= '0;
                        frame_pass     <= 1'b0;
                        first_err_line <= 5'h1F;
                        first_err_pix  <= 12'hFFF;
                    end
                end
                S_LINE: begin
                    if (line_close) begin
                        line_err     <= line_has_err | mismatch | short_line;
                        line_has_err <= 1'b0;
                        line_idx     <= line_idx + 5'd1;
                        y_acc        <= y_acc + dy_r;
                        x_acc        <= y_acc + dy_r;
                        pix_idx      <= '0;
                        if (last_line) begin
                            state <= S_DONE;
                        end else if (short_line) begin
                            state <= S_LINE;
                        end else begin
                            state <= S_GAP;
                        end
                    end else if (pix_acc) begin
                        pix_idx      <= pix_idx + PW'(1);
                        x_acc        <= x_acc + dx_r;
                        line_has_err <= line_has_err | mismatch;
                    end
                end
                S_GAP: begin
                    if (sync) begin
                        state   <= S_LINE;
                        pix_idx <= '0;
                    end
                end
                default: begin
                    // The pending error event is folded in so the verdict matches the final count
                    frame_done <= 1'b1;
                    frame_pass <= (err_cnt == 16'd0) && !err_evt;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_checker.sv
// Directed frames with hand-computed verdicts; a monitor checks each frame_done against a queue.
// Uses a scaled instance (40-pixel lines, 64-pixel REGULAR lines, 12 lines) to keep runtime short.
module tb_pattern_checker;
    localparam int DW = 12;
    localparam int LL = 40;
    localparam int RL = 64;
    localparam int NL = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_sync = 1'b0;
    logic        sync = 1'b0;
    logic [2:0]  mode = 3'b000;
    logic [11:0] const_val = '0;
    logic [1:0]  x_sel = '0;
    logic [1:0]  y_sel = '0;
    logic        pix_valid = 1'b0;
    logic [11:0] pix_data = '0;
    logic        busy;
    logic [15:0] err_cnt;
    logic        line_err;
    logic        frame_done;
    logic        frame_pass;
    logic [4:0]  first_err_line;
    logic [11:0] first_err_pix;

    pattern_checker #(.DW(DW), .LINE_LEN(LL), .REG_LEN(RL), .LINES(NL)) dut (
        .clk(clk), .rst_n(rst_n), .f_sync(f_sync), .sync(sync), .mode(mode),
        .const_val(const_val), .x_sel(x_sel), .y_sel(y_sel),
        .pix_valid(pix_valid), .pix_data(pix_data), .busy(busy), .err_cnt(err_cnt),
        .line_err(line_err), .frame_done(frame_done), .frame_pass(frame_pass),
        .first_err_line(first_err_line), .first_err_pix(first_err_pix)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int ecnt;
        int pass;
        int fline;
        int fpix;
        int lerrs;
    } exp_t;

    exp_t sbq[$];
    int n_vec = 0;
    int n_bad = 0;
    int lerr_seen = 0;
    int last_vld_cyc = 0;

    int          ov_n = 0;
    int          ov_l[8];
    int          ov_p[8];
    logic [11:0] ov_v[8];

    task automatic chk(input string nm, input int act, input int want);
        n_vec++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, want);
        end
    endtask

    function automatic logic [11:0] gen(input int gm, input int l, input int p,
                                        input logic [11:0] cv, input int dx, input int dy);
        case (gm)
            1: return 12'(p ^ (p >> 1));
            2: return cv;
            3: return (((p + l) & 1) != 0) ? 12'hFFF : 12'h000;
            4: return (((p + l) & 1) != 0) ? 12'h000 : 12'hFFF;
            5: return ((((p + 2 * ((l >> 1) & 1)) >> 1) & 1) != 0) ? 12'hFFF : 12'h000;
            6: return ((((p + 2 * ((l >> 1) & 1)) >> 1) & 1) != 0) ? 12'h000 : 12'hFFF;
            7: return 12'(l * dy + p * dx);
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] px(input int gm, input int l, input int p,
                                       input logic [11:0] cv, input int dx, input int dy);
        for (int i = 0; i < ov_n; i++)
            if (ov_l[i] == l && ov_p[i] == p) return ov_v[i];
        return gen(gm, l, p, cv, dx, dy);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ov(input int i, input int l, input int p, input logic [11:0] v);
        ov_l[i] = l;
        ov_p[i] = p;
        ov_v[i] = v;
    endtask

    // Drives one frame; inputs that should be latched only at frame start are scrambled afterwards
    task automatic run_frame(input logic [2:0] m, input logic [11:0] cv, input logic [1:0] xs,
                             input logic [1:0] ys, input int gm, input int gdx, input int gdy,
                             input int short_l, input int short_n, input int gap_l,
                             input int gap_n, input int abort_l);
        int n;
        mode = m; const_val = cv; x_sel = xs; y_sel = ys;
        f_sync = 1'b1; sync = 1'b1; pix_valid = 1'b1; pix_data = 12'h5A5;
        tick();
        f_sync = 1'b0; sync = 1'b0; pix_valid = 1'b0;
        mode = ~m; const_val = ~cv; x_sel = ~xs; y_sel = ~ys;
        for (int l = 0; l < NL; l++) begin
            n = (l == short_l) ? short_n : ((m == 3'b001) ? RL : LL);
            for (int p = 0; p < n; p++) begin
                if (p % 7 == 3) begin
                    pix_valid = 1'b0;
                    tick();
                end
                if (l == 0 && p == 0) chk("busy_in_frame", int'(busy), 1);
                if (l == abort_l && p == 5) begin
                    pix_valid = 1'b0;
                    return;
                end
                pix_valid = 1'b1;
                pix_data = px(gm, l, p, cv, gdx, gdy);
                last_vld_cyc = cyc;
                tick();
            end
            pix_valid = 1'b0;
            if (l == NL - 1) break;
            if (l != short_l) begin
                tick();
                if (l == gap_l) begin
                    for (int g = 0; g < gap_n; g++) begin
                        pix_valid = 1'b1;
                        pix_data = 12'h123;
                        tick();
                    end
                    pix_valid = 1'b0;
                end
                tick();
            end
            sync = 1'b1; pix_valid = 1'b1; pix_data = 12'h5A5;
            tick();
            sync = 1'b0; pix_valid = 1'b0;
        end
        repeat (4) tick();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_err_cnt"}, int'(err_cnt), 0);
        chk({tag, "_line_err"}, int'(line_err), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_frame_pass"}, int'(frame_pass), 0);
        chk({tag, "_first_err_line"}, int'(first_err_line), 31);
        chk({tag, "_first_err_pix"}, int'(first_err_pix), 4095);
    endtask

    exp_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            lerr_seen = 0;
        end else begin
            if (line_err) lerr_seen++;
            if (frame_done) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_frame_done: got frame_done=1, expected 0");
                end else begin
                    e = sbq.pop_front();
                    chk("err_cnt", int'(err_cnt), e.ecnt);
                    chk("frame_pass", int'(frame_pass), e.pass);
                    chk("first_err_line", int'(first_err_line), e.fline);
                    chk("first_err_pix", int'(first_err_pix), e.fpix);
                    chk("line_err_pulses", lerr_seen, e.lerrs);
                    chk("done_latency", cyc - last_vld_cyc, 2);
                end
                lerr_seen = 0;
            end
        end
    end

    initial begin
        repeat (3) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();

        // REGULAR, clean
        ov_n = 0;
        sbq.push_back('{0, 1, 31, 4095, 0});
        run_frame(3'b001, 12'h000, 2'b00, 2'b00, 1, 0, 0, -1, 0, -1, 0, -1);

        // CONST 0xA5A with one corrupted pixel at line 3, pixel 10
        ov_n = 1;
        set_ov(0, 3, 10, 12'hA5B);
        sbq.push_back('{1, 0, 3, 10, 1});
        run_frame(3'b010, 12'hA5A, 2'b00, 2'b00, 2, 0, 0, -1, 0, -1, 0, -1);

        // RAMP dX=4 dY=1290, clean, with hand-written samples pinned
        ov_n = 3;
        set_ov(0, 1, 0, 12'd1290);
        set_ov(1, 1, 2, 12'd1298);
        set_ov(2, 4, 1, 12'd1068);
        sbq.push_back('{0, 1, 31, 4095, 0});
        run_frame(3'b111, 12'h000, 2'b10, 2'b11, 7, 4, 1290, -1, 0, -1, 0, -1);

        // RAMP expecting dX=4 but fed dX=1: only P=0 matches, 39 errors per line
        ov_n = 0;
        sbq.push_back('{39 * NL, 0, 0, 1, NL});
        run_frame(3'b111, 12'h000, 2'b10, 2'b11, 7, 1, 1290, -1, 0, -1, 0, -1);

        // WHITE2x2, clean, with hand-written line 0 and line 2 starts
        ov_n = 8;
        set_ov(0, 0, 0, 12'h000); set_ov(1, 0, 1, 12'h000);
        set_ov(2, 0, 2, 12'hFFF); set_ov(3, 0, 3, 12'hFFF);
        set_ov(4, 2, 0, 12'hFFF); set_ov(5, 2, 1, 12'hFFF);
        set_ov(6, 2, 2, 12'h000); set_ov(7, 2, 3, 12'h000);
        sbq.push_back('{0, 1, 31, 4095, 0});
        run_frame(3'b101, 12'h000, 2'b00, 2'b00, 5, 0, 0, -1, 0, -1, 0, -1);

        // WHITE2x2 expected, BLACK2x2 stream: every pixel wrong
        ov_n = 0;
        sbq.push_back('{LL * NL, 0, 0, 0, NL});
        run_frame(3'b101, 12'h000, 2'b00, 2'b00, 6, 0, 0, -1, 0, -1, 0, -1);

        // WHITE1x1 with line 5 cut short after 20 pixels
        sbq.push_back('{1, 0, 5, 4095, 1});
        run_frame(3'b011, 12'h000, 2'b00, 2'b00, 3, 0, 0, 5, 20, -1, 0, -1);

        // BLACK1x1 with 3 overrun pixels in the gap after line 0
        sbq.push_back('{3, 0, 0, LL, 0});
        run_frame(3'b100, 12'h000, 2'b00, 2'b00, 4, 0, 0, -1, 0, 0, 3, -1);

        // REGULAR with an error on line 2, then reset during line 10
        ov_n = 1;
        set_ov(0, 2, 7, 12'hFFF);
        run_frame(3'b001, 12'h000, 2'b00, 2'b00, 1, 0, 0, -1, 0, -1, 0, 10);
        chk("pre_reset_err_cnt", int'(err_cnt), 1);
        chk("pre_reset_busy", int'(busy), 1);
        chk("pre_reset_first_err_line", int'(first_err_line), 2);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midframe_reset");
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_reset_busy", int'(busy), 0);

        // Frame start with mode 000 must be ignored
        ov_n = 0;
        mode = 3'b000;
        f_sync = 1'b1; sync = 1'b1;
        tick();
        f_sync = 1'b0; sync = 1'b0;
        repeat (3) tick();
        chk("mode0_busy", int'(busy), 0);
        for (int i = 0; i < 10; i++) begin
            pix_valid = 1'b1;
            pix_data = 12'hFFF;
            tick();
        end
        pix_valid = 1'b0;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        repeat (3) tick();
        chk("mode0_busy_after_pixels", int'(busy), 0);
        chk("mode0_err_cnt", int'(err_cnt), 0);

        for (int i = 0; i < 200 && sbq.size() > 0; i++) tick();
        if (sbq.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL frame_done_timeout: got %0d outstanding frames, expected 0", sbq.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pattern_checker.md
Name: pattern_checker

Overview:
- Receiver-side counterpart of the pattern generator: consumes the generated pixel stream, recomputes the expected pixel for every position, and counts mismatches per frame.
- Sits at the generator output, or at the far end of the video link.
- Used in silicon self-test and as a scoreboard in verification.
- Reports a per-frame pass/fail verdict and the location of the first error.

Parameters:
- DW, 12, pixel width.
- LINE_LEN, 1290, pixels per line for every mode except REGULAR.
- REG_LEN, 4096, pixels per line in REGULAR mode.
- LINES, 24, lines per frame.

Ports:
- clk  in  1  master clock.
- rst_n  in  1  asynchronous active-low reset.
- f_sync  in  1  first-sync qualifier; f_sync&sync marks frame start.
- sync  in  1  line-start strobe.
- mode  in  3  001 REGULAR, 010 CONST, 011 WHITE1x1, 100 BLACK1x1, 101 WHITE2x2, 110 BLACK2x2, 111 RAMP; 000 invalid.
- const_val  in  DW  expected value in CONST mode.
- x_sel  in  2  RAMP dX: 00→0, 01→1, 10→4, 11→8.
- y_sel  in  2  RAMP dY: 00→0, 01→1, 10→16, 11→1290.
- pix_valid  in  1  qualifies pix_data.
- pix_data  in  DW  received pixel.
- busy  out  1  frame in progress.
- err_cnt  out  16  mismatches this frame; saturates at 0xFFFF.
- line_err  out  1  one-cycle pulse when a line closes with at least one error.
- frame_done  out  1  one-cycle pulse at frame end.
- frame_pass  out  1  valid from frame_done until the next frame start; 1 when err_cnt==0.
- first_err_line  out  5  line index of the first error.
- first_err_pix  out  12  pixel index of the first error; 0xFFF marks a short-line error.

Behaviour:
- Reset state:
  - All outputs 0; state IDLE.
  - first_err_line=0x1F, first_err_pix=0xFFF.
- States: IDLE, LINE, GAP, DONE.
- IDLE → LINE on f_sync&sync with mode≠000. Actions on that transition:
  - Clear err_cnt and frame_pass.
  - Set line index L=0 and pixel index P=0.
  - Capture mode, const_val, dX and dY.
  - Set busy=1.
  - f_sync&sync with mode=000 is ignored; the block stays in IDLE.
- Mode/const/dX/dY are registered at frame start only. Changes mid-frame are ignored.
- Pixel timing:
  - A pix_valid on the same cycle as sync is ignored.
  - Pixels are counted from the cycle after sync.
- LINE: each pix_valid compares pix_data to expected E(L,P), then P++.
- Expected pixel E(L,P) by mode (all arithmetic mod 2^DW):
  - REGULAR: P ^ (P>>1).
  - CONST: const_val.
  - WHITE1x1: ((P+L)&1) ? 0xFFF : 0x000. BLACK1x1: the inverse.
  - WHITE2x2: bit1 of (P + 2*((L>>1)&1)) ? 0xFFF : 0x000. BLACK2x2: the inverse.
  - RAMP: Y_L + P*dX, where Y_L accumulates dY per completed line (Y_0=0). Implement with accumulators, no multiplier.
- Error update:
  - On mismatch, err_cnt increments 1 cycle after the pixel (registered compare).
  - The first mismatch of the frame loads first_err_line/first_err_pix.
- Line complete: when P reaches the line length (REG_LEN or LINE_LEN):
  - Close the line and pulse line_err if the line had errors.
  - Then L++ and Y_L += dY.
  - If L was LINES-1, go to DONE; otherwise go to GAP.
- GAP:
  - Each pix_valid is an overrun error: err_cnt++ and first-error capture with P=LINE_LEN.
  - sync → LINE with P=0.
- Short line:
  - sync while in LINE with P<length counts as one error; first_err_pix=0xFFF.
  - The line closes (L advances) and the new line starts in the same cycle.
  - If the closing line was the last, go to DONE.
- DONE, one cycle:
  - Pulse frame_done, set frame_pass=(err_cnt==0), busy=0.
  - Go to IDLE.
  - A sync arriving during DONE is ignored.
- Latency: frame_done follows the last pixel's valid by 2 cycles. err_cnt is final when frame_done is asserted.
- Simultaneous events:
  - A mismatch and a line close in the same cycle: both are counted.
  - err_cnt saturation also holds first_err_* unchanged.
- Reset mid-frame: returns immediately to the reset state; no frame_done is issued.

Test Plan:
- REGULAR, clean generator stream, 24 lines × 4096 pixels → 24 line closes, no line_err, frame_done with frame_pass=1, err_cnt=0.
- CONST const_val=0xA5A; pixel L=3, P=100 forced to 0xA5B → err_cnt=1, first_err_line=3, first_err_pix=100, line_err pulses once (line 3), frame_pass=0.
- RAMP x_sel=10, y_sel=11:
  - E(1,0)=1290, E(1,2)=1298, E(4,1)=(5160+4) mod 4096=1068.
  - A clean stream passes.
  - A stream with dX=1 fails, err_cnt=1289×24=30936.
- WHITE2x2 expected values: line 0 starts 000,000,FFF,FFF; line 2 starts FFF,FFF,000,000.
- WHITE2x2 with a BLACK2x2 stream → err_cnt=1290×24=30960, first_err_line=0, first_err_pix=0.
- sync after 1000 pixels on line 5 → err_cnt=1, first_err_pix=0xFFF, line 6 starts at P=0.
- 3 extra valid pixels in GAP after line 0 → err_cnt=3, first_err_pix=1290.
- rst_n low at line 10 → all outputs return to reset values, no frame_done.
- f_sync&sync with mode=000 → block stays in IDLE, busy=0.
